result_bcd_formatter: RTL

- Downstream consumer of the ALU/bitwise result bus: takes one 32-bit signed result and converts it to sign plus packed BCD digits for the 7-segment display driver.
- Sequential double-dabble converter, one shift per clock.
- Valid/ready handshake on both sides, so the display stage can stall it.

---
 rtl/result_bcd_formatter_if.sv | 25 ++
 rtl/result_bcd_formatter.sv | 103 ++++++++++
 2 files changed

// File: rtl/result_bcd_formatter_if.sv
// Handshake bundle between the ALU result bus, the BCD formatter and the display stage.
// The master side is the producer of results and the consumer of the display fields.
interface result_bcd_formatter_if #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_W-1:0]       in_result;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sign;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [3:0]            out_ndigits;

    modport master (
        output in_valid, in_result, out_ready,
        input  in_ready, out_valid, out_sign, out_bcd, out_ndigits
    );

    modport slave (
        input  in_valid, in_result, out_ready,
        output in_ready, out_valid, out_sign, out_bcd, out_ndigits
    );
endinterface

// File: rtl/result_bcd_formatter.sv
// Signed 32-bit result to sign + packed BCD, one double-dabble shift per clock.
// state | meaning: IDLE accept a result | SHIFT adjust and shift | DONE hold output for display
module result_bcd_formatter #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    result_bcd_formatter_if.slave   bus
);
    localparam int CNT_W = $clog2(IN_W);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [IN_W-1:0]       r_mag;
    logic [4*DIGITS-1:0]   r_scratch;
    logic [CNT_W-1:0]      r_count;
    logic                  r_sign_next;
    logic                  r_sign;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [3:0]            r_ndigits;

    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_scratch_sh;
    logic [3:0]            w_nd;
    logic                  w_last;

    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
        w_scratch_sh = {w_adj[4*DIGITS-2:0], r_mag[IN_W-1]};
        // Highest nonzero digit wins; all-zero still shows one digit.
        w_nd = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_scratch_sh[4*i +: 4] != 4'd0)
                w_nd = 4'(i + 1);
        end
    end

    assign w_last = (r_count == LAST_SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)        w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mag       <= '0;
            r_scratch   <= '0;
            r_count     <= '0;
            r_sign_next <= 1'b0;
            r_sign      <= 1'b0;
            r_bcd       <= '0;
            r_ndigits   <= 4'd1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign_next <= bus.in_result[IN_W-1];
                        r_mag       <= bus.in_result[IN_W-1] ? (~bus.in_result + IN_W'(1))
                                                             : bus.in_result;
                        r_scratch   <= '0;
                        r_count     <= '0;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_scratch_sh;
                    r_mag     <= {r_mag[IN_W-2:0], 1'b0};
                    r_count   <= r_count + 1'b1;
                    if (w_last) begin
                        r_sign    <= r_sign_next;
                        r_bcd     <= w_scratch_sh;
                        r_ndigits <= w_nd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.out_sign    = r_sign;
    assign bus.out_bcd     = r_bcd;
    assign bus.out_ndigits = r_ndigits;
endmodule
